// File: rtl/fixed_latency_mul_issue_if.sv
// ----------------------------------------------------------------------------
// fixed_latency_mul_issue_if
// Valid/ready/data handshake bundle that carries operand pairs into the
// multiply issue stage.
//   valid  producer -> consumer  data is presented this cycle
//   ready  consumer -> producer  consumer takes data on valid & ready
//   data   producer -> consumer  payload, W bits wide
// Modports: master drives valid/data, slave drives ready.
// ----------------------------------------------------------------------------
interface fixed_latency_mul_issue_if #(
    parameter int unsigned W = 32
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fixed_latency_mul_issue.sv
// ----------------------------------------------------------------------------
// fixed_latency_mul_issue
// Credit-gated issue stage in front of a fixed-latency decoupler. Operand
// pairs {B,A} are accepted on din, multiplied at full width and carried
// through a LATENCY-deep register pipeline with no backpressure. Issue is
// allowed only while a downstream buffer slot is free, so a result can
// never arrive at a full buffer.
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous reset, active low
//   din           operand handshake (slave side), data = {B, A}
//   i_credit_ret  one pulse per item popped from the downstream buffer
//   o_pipe_valid  result valid, one cycle per accepted operand pair
//   o_pipe_data   full-width product A*B
//   o_credits     free downstream slots
//   o_busy        items in flight or still buffered downstream
//   o_err         sticky: credit returned while the counter was already full
// ----------------------------------------------------------------------------
module fixed_latency_mul_issue #(
    parameter int unsigned A_W     = 16,
    parameter int unsigned B_W     = 16,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned SIGNED  = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    fixed_latency_mul_issue_if.slave     din,
    input  logic                         i_credit_ret,
    output logic                         o_pipe_valid,
    output logic [A_W+B_W-1:0]           o_pipe_data,
    output logic [$clog2(CREDITS+1)-1:0] o_credits,
    output logic                         o_busy,
    output logic                         o_err
);
    localparam int unsigned W  = A_W + B_W;
    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CreditsMax = CW'(CREDITS);

    logic [CW-1:0]      r_credits;
    logic               r_err;
    logic [LATENCY-1:0] r_valid;
    logic [W-1:0]       r_data [LATENCY];

    logic         w_ready;
    logic         w_fire;
    logic [W-1:0] w_a_ext;
    logic [W-1:0] w_b_ext;
    logic [W-1:0] w_product;

    // Ready is a function of reset and registered credit state only.
    assign w_ready   = i_rst & (r_credits != '0);
    assign din.ready = w_ready;
    assign w_fire    = din.valid & w_ready;

    // Extending both operands to W bits (sign or zero) and keeping the low W
    // bits of the product gives the exact full-width result in either mode.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_ext = {{B_W{din.data[A_W-1]}}, din.data[A_W-1:0]};
            assign w_b_ext = {{A_W{din.data[W-1]}}, din.data[W-1:A_W]};
        end else begin : g_unsigned
            assign w_a_ext = {{B_W{1'b0}}, din.data[A_W-1:0]};
            assign w_b_ext = {{A_W{1'b0}}, din.data[W-1:A_W]};
        end
    endgenerate

    assign w_product = w_a_ext * w_b_ext;

    // Valid bits: cleared by reset, so in-flight results vanish on reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= w_fire;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Data stages are not reset; contents only matter alongside a valid bit.
    always_ff @(posedge i_clk) begin
        r_data[0] <= w_product;
        for (int i = 1; i < LATENCY; i++) begin
            r_data[i] <= r_data[i-1];
        end
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_credits <= CreditsMax;
            r_err     <= 1'b0;
        end else begin
            unique case ({w_fire, i_credit_ret})
                2'b10: r_credits <= r_credits - CW'(1);
                2'b01: begin
                    if (r_credits == CreditsMax) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + CW'(1);
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign o_pipe_valid = r_valid[LATENCY-1];
    assign o_pipe_data  = r_data[LATENCY-1];
    assign o_credits    = r_credits;
    assign o_busy       = (r_credits != CreditsMax) | (|r_valid);
    assign o_err        = r_err;

endmodule
